// File: rtl/hangman_round_ctrl_if.sv
// Guess/word handshake and display bus between a hangman round controller
// and the logic that drives it. The master side drives word and guess requests.
interface hangman_round_ctrl_if;
  // Handshake: a guess transfers on a rising clk edge where guess_valid && guess_ready;
  // the master holds guess_valid/guess_letter stable until then. word_load is a
  // one-cycle pulse that is always taken and overrides any guess in the same cycle.
  logic        word_load;
  logic [29:0] word_in;
  logic        guess_valid;
  logic [4:0]  guess_letter;
  logic        guess_ready;
  logic [29:0] display_word;
  logic [5:0]  reveal_mask;
  logic [3:0]  miss_count;
  logic        hit;
  logic        miss;
  logic        win;
  logic        lose;

  modport master (
    output word_load, word_in, guess_valid, guess_letter,
    input  guess_ready, display_word, reveal_mask, miss_count, hit, miss, win, lose
  );

  modport slave (
    input  word_load, word_in, guess_valid, guess_letter,
    output guess_ready, display_word, reveal_mask, miss_count, hit, miss, win, lose
  );
endinterface

// File: rtl/hangman_round_ctrl.sv
// One hangman round over six 5-bit letter slots: latch the word, check guesses
// against all slots in parallel, reveal matches, count misses, end in WIN or LOSE.
module hangman_round_ctrl #(
  parameter int         MAX_MISS = 6,
  parameter logic [4:0] BLANK    = 5'd31
) (
  input  logic                 clk,
  input  logic                 resetn,
  hangman_round_ctrl_if.slave  bus,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_t;

  localparam logic [3:0]  MAX_MISS_C = 4'(MAX_MISS);
  localparam logic [29:0] ALL_BLANK  = {6{BLANK}};

  state_t      state_q;
  logic [29:0] word_q;
  logic [4:0]  guess_q;
  logic [5:0]  reveal_q;
  logic [29:0] disp_q;
  logic [3:0]  miss_cnt_q;
  logic        hit_q;
  logic        miss_q;

  logic [5:0]  match;
  logic [5:0]  new_bits;
  logic [5:0]  reveal_d;
  logic [29:0] disp_d;
  logic [3:0]  miss_cnt_d;

  // Mask bit j covers word bits [5j+4:5j], so bit5 is slot1 and bit0 is slot6.
  always_comb begin
    match    = '0;
    disp_d   = disp_q;
    for (int j = 0; j < 6; j++) begin
      match[j] = (word_q[5*j +: 5] == guess_q);
    end
    new_bits = match & ~reveal_q;
    reveal_d = reveal_q | new_bits;
    for (int j = 0; j < 6; j++) begin
      if (new_bits[j]) disp_d[5*j +: 5] = word_q[5*j +: 5];
    end
    miss_cnt_d = miss_cnt_q;
    if (match == 6'd0 && miss_cnt_q < MAX_MISS_C) miss_cnt_d = miss_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      guess_q    <= '0;
      reveal_q   <= '0;
      disp_q     <= ALL_BLANK;
      miss_cnt_q <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      if (bus.word_load) begin
        word_q     <= bus.word_in;
        reveal_q   <= '0;
        disp_q     <= ALL_BLANK;
        miss_cnt_q <= '0;
        state_q    <= S_PLAY;
      end else begin
        case (state_q)
          S_PLAY: begin
            // A BLANK guess is consumed here and never reaches CHECK.
            if (bus.guess_valid && bus.guess_letter != BLANK) begin
              guess_q <= bus.guess_letter;
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            reveal_q   <= reveal_d;
            disp_q     <= disp_d;
            miss_cnt_q <= miss_cnt_d;
            hit_q      <= (new_bits != 6'd0);
            miss_q     <= (match == 6'd0);
            if (reveal_d == 6'b111111) begin
              state_q <= S_WIN;
            end else if (miss_cnt_d == MAX_MISS_C) begin
              state_q  <= S_LOSE;
              reveal_q <= 6'b111111;
              disp_q   <= word_q;
            end else begin
              state_q <= S_PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.guess_ready  = (state_q == S_PLAY);
  assign bus.display_word = disp_q;
  assign bus.reveal_mask  = reveal_q;
  assign bus.miss_count   = miss_cnt_q;
  assign bus.hit          = hit_q;
  assign bus.miss         = miss_q;
  assign bus.win          = (state_q == S_WIN);
  assign bus.lose         = (state_q == S_LOSE);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Directed table-driven bench for hangman_round_ctrl, with hand-written
// sequences for reset behaviour and reset during CHECK.
module tb_hangman_round_ctrl;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PLAY  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_WIN   = 3'd3;
  localparam logic [2:0] ST_LOSE  = 3'd4;

  localparam logic [29:0] W1  = {5'd7, 5'd0, 5'd13, 5'd6, 5'd12, 5'd13};
  localparam logic [29:0] AB  = {6{5'd31}};
  localparam logic [29:0] D_N = {5'd31, 5'd31, 5'd13, 5'd31, 5'd31, 5'd13};

  typedef struct {
    logic        ld;
    logic [29:0] wi;
    logic        gv;
    logic [4:0]  gl;
    logic [2:0]  st;
    logic [29:0] disp;
    logic [5:0]  rev;
    logic [3:0]  cnt;
    logic        hit;
    logic        miss;
  } vec_t;

  logic       clk;
  logic       resetn;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;
  vec_t       vecs[$];

  hangman_round_ctrl_if bus ();

  hangman_round_ctrl #(.MAX_MISS(6), .BLANK(5'd31)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input logic [2:0] st, input logic [29:0] disp,
                               input logic [5:0] rev, input logic [3:0] cnt,
                               input logic h, input logic m);
    chk("state",        idx, 32'(dbg_state),        32'(st));
    chk("guess_ready",  idx, 32'(bus.guess_ready),  32'(st == ST_PLAY));
    chk("display_word", idx, 32'(bus.display_word), 32'(disp));
    chk("reveal_mask",  idx, 32'(bus.reveal_mask),  32'(rev));
    chk("miss_count",   idx, 32'(bus.miss_count),   32'(cnt));
    chk("hit",          idx, 32'(bus.hit),          32'(h));
    chk("miss",         idx, 32'(bus.miss),         32'(m));
    chk("win",          idx, 32'(bus.win),          32'(st == ST_WIN));
    chk("lose",         idx, 32'(bus.lose),         32'(st == ST_LOSE));
  endtask

  function automatic void add(input logic ld, input logic [29:0] wi, input logic gv,
                              input logic [4:0] gl, input logic [2:0] st, input logic [29:0] disp,
                              input logic [5:0] rev, input logic [3:0] cnt,
                              input logic h, input logic m);
    vec_t v;
    v.ld = ld; v.wi = wi; v.gv = gv; v.gl = gl; v.st = st;
    v.disp = disp; v.rev = rev; v.cnt = cnt; v.hit = h; v.miss = m;
    vecs.push_back(v);
  endfunction

  // driver: apply one record for one clock, then compare just after the edge
  task automatic apply(input vec_t v, input int idx);
    bus.word_load    = v.ld;
    bus.word_in      = v.wi;
    bus.guess_valid  = v.gv;
    bus.guess_letter = v.gl;
    @(posedge clk);
    #1;
    check_outputs(idx, v.st, v.disp, v.rev, v.cnt, v.hit, v.miss);
  endtask

  initial begin
    logic [4:0]  win_letters[5];
    logic [5:0]  win_masks[5];
    logic [29:0] win_disps[5];
    logic [29:0] prev_disp;
    logic [5:0]  prev_mask;

    checks = 0;
    errors = 0;
    bus.word_load    = 1'b0;
    bus.word_in      = '0;
    bus.guess_valid  = 1'b0;
    bus.guess_letter = '0;

    win_letters = '{5'd7, 5'd0, 5'd13, 5'd6, 5'd12};
    win_masks   = '{6'b100000, 6'b110000, 6'b111001, 6'b111101, 6'b111111};
    win_disps   = '{{5'd7, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31},
                    {5'd7, 5'd0,  5'd31, 5'd31, 5'd31, 5'd31},
                    {5'd7, 5'd0,  5'd13, 5'd31, 5'd31, 5'd13},
                    {5'd7, 5'd0,  5'd13, 5'd6,  5'd31, 5'd13},
                    W1};

    // Vector table: ld, word, gv, letter | state, display, mask, count, hit, miss
    add(0, '0, 1, 5'd7,  ST_IDLE,  AB,  6'b000000, 0, 0, 0);
    add(1, W1, 0, 5'd0,  ST_PLAY,  AB,  6'b000000, 0, 0, 0);
    add(0, '0, 1, 5'd13, ST_CHECK, AB,  6'b000000, 0, 0, 0);
    add(0, '0, 0, 5'd0,  ST_PLAY,  D_N, 6'b001001, 0, 1, 0);
    add(0, '0, 0, 5'd0,  ST_PLAY,  D_N, 6'b001001, 0, 0, 0);
    add(0, '0, 1, 5'd13, ST_CHECK, D_N, 6'b001001, 0, 0, 0);
    add(0, '0, 0, 5'd0,  ST_PLAY,  D_N, 6'b001001, 0, 0, 0);
    add(0, '0, 1, 5'd31, ST_PLAY,  D_N, 6'b001001, 0, 0, 0);
    add(0, '0, 0, 5'd0,  ST_PLAY,  D_N, 6'b001001, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      add(0, '0, 1, 5'd25, ST_CHECK, D_N, 6'b001001, 4'(k - 1), 0, 0);
      if (k < 6) add(0, '0, 0, 5'd0, ST_PLAY, D_N, 6'b001001, 4'(k), 0, 1);
      else       add(0, '0, 0, 5'd0, ST_LOSE, W1,  6'b111111, 4'd6, 0, 1);
    end
    add(0, '0, 1, 5'd7,  ST_LOSE,  W1,  6'b111111, 6, 0, 0);
    add(0, '0, 1, 5'd25, ST_LOSE,  W1,  6'b111111, 6, 0, 0);
    // word_load together with a guess: the guess must be dropped
    add(1, W1, 1, 5'd7,  ST_PLAY,  AB,  6'b000000, 0, 0, 0);
    add(0, '0, 0, 5'd0,  ST_PLAY,  AB,  6'b000000, 0, 0, 0);
    prev_disp = AB;
    prev_mask = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      add(0, '0, 1, win_letters[i], ST_CHECK, prev_disp, prev_mask, 0, 0, 0);
      add(0, '0, 0, 5'd0, (i == 4) ? ST_WIN : ST_PLAY, win_disps[i], win_masks[i], 0, 1, 0);
      prev_disp = win_disps[i];
      prev_mask = win_masks[i];
    end
    add(0, '0, 1, 5'd25, ST_WIN,   W1,  6'b111111, 0, 0, 0);
    add(0, '0, 0, 5'd0,  ST_WIN,   W1,  6'b111111, 0, 0, 0);

    // reset block
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(-1, ST_IDLE, AB, 6'b000000, 0, 0, 0);
    resetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // reset asserted while in CHECK
    bus.word_load = 1'b1; bus.word_in = W1; bus.guess_valid = 1'b0;
    @(posedge clk); #1;
    bus.word_load = 1'b0; bus.guess_valid = 1'b1; bus.guess_letter = 5'd13;
    @(posedge clk); #1;
    bus.guess_valid = 1'b0;
    chk("in_check", 100, 32'(dbg_state), 32'(ST_CHECK));
    #2;
    resetn = 1'b0;
    #1;
    check_outputs(101, ST_IDLE, AB, 6'b000000, 0, 0, 0);
    @(posedge clk); #1;
    check_outputs(102, ST_IDLE, AB, 6'b000000, 0, 0, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check_outputs(103, ST_IDLE, AB, 6'b000000, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hangman_round_ctrl.md
Name: hangman_round_ctrl

Overview:
- Sequences one hangman round over a six-slot letter display.
- Latches the secret word, accepts letter guesses one at a time, and compares each guess against all six slots in parallel.
- Reveals matching slots into the display register and counts misses.
- Declares win or lose; downstream display/segment logic consumes display_word and the status flags.

Parameters:
MAX_MISS, 6, wrong guesses that end the round as a loss (1..15)
BLANK, 5'd31, letter code driven for an unrevealed slot; also treated as an invalid guess

Ports:
clk  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
word_load  input  1  single-cycle pulse, latch word_in and start a new round
word_in  input  30  six 5-bit letter codes, slot1 in [29:25] ... slot6 in [4:0]
guess_valid  input  1  guess request; held until accepted
guess_letter  input  5  letter code of the guess
guess_ready  output  1  high only in PLAY; guess accepted when guess_valid && guess_ready
display_word  output  30  revealed letters, same packing as word_in; BLANK for hidden slots
reveal_mask  output  6  bit5 = slot1 ... bit0 = slot6; 1 = revealed
miss_count  output  4  wrong guesses this round
hit  output  1  one-cycle pulse: last evaluated guess revealed at least one new slot
miss  output  1  one-cycle pulse: last evaluated guess counted as a miss
win  output  1  level, high in WIN
lose  output  1  level, high in LOSE

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; secret word = 0; reveal_mask = 0; display_word = all BLANK; miss_count = 0; hit = miss = win = lose = guess_ready = 0.
- States: IDLE, PLAY, CHECK, WIN, LOSE.
- word_load in any state (highest priority):
  - latch word_in, clear reveal_mask and miss_count, display all BLANK;
  - next state PLAY;
  - a guess_valid in the same cycle is ignored.
- PLAY:
  - guess_ready = 1.
  - On accept: register guess_letter, go to CHECK.
  - A guess equal to BLANK is accepted but treated as a no-op: no hit, no miss, no count change, return to PLAY.
- CHECK (exactly one cycle):
  - match[i] = (slot_i == guess), computed for all six slots.
  - new = match & ~reveal_mask.
  - If new != 0: reveal_mask |= new; display_word slot i <= slot_i for each new bit; pulse hit.
  - Else if match != 0 (letter already revealed): no pulse, no count change.
  - Else: miss_count += 1; pulse miss.
  - Next state from the updated values:
    - reveal_mask == 6'b111111 -> WIN;
    - else miss_count == MAX_MISS -> LOSE;
    - else PLAY.
  - A full reveal and the final miss cannot occur in the same guess.
- Latency: the accept edge moves to CHECK; on the following edge display_word, reveal_mask, miss_count, hit/miss and the win/lose state all update together. A new guess can be accepted the cycle after that, so throughput is one guess per 2 cycles.
- hit and miss are registered, high for exactly one cycle, and never both high.
- WIN / LOSE: terminal until word_load.
  - guess_ready = 0.
  - In LOSE, display_word shows the full secret word and reveal_mask = 6'b111111; miss_count holds.
  - In WIN, miss_count holds.
- miss_count saturates at MAX_MISS and never wraps.
- IDLE: guess_ready = 0; guesses ignored.
- Duplicate word letters: one guess reveals every matching slot in the same CHECK cycle.
- Reset asserted mid-CHECK: all outputs return to reset values immediately; no pulse is emitted.

Test Plan:
1. Reset, then word_load with "HANGMN" (H=7, A=0, N=13, G=6, M=12) -> after 1 cycle: state PLAY, guess_ready = 1, display_word all 5'd31, miss_count = 0.
2. Guess N (13) -> 2 cycles after accept: reveal_mask = 6'b001001, slots 3 and 6 = 13, hit pulse for 1 cycle, miss_count = 0.
3. Guess N again, then guess BLANK -> no hit, no miss, reveal_mask unchanged, miss_count = 0.
4. Guess Z (25) six times with MAX_MISS = 6 -> miss pulse each time, miss_count 1..6, lose = 1 after the 6th, display_word = "HANGMN", guess_ready = 0, a further guess is ignored.
5. New word_load, then guess H, A, N, G, M -> win = 1 two cycles after the M accept, reveal_mask = 6'b111111, miss_count = 0.
6. Pulse resetn low during CHECK -> outputs return to reset values asynchronously; a word_load coinciding with guess_valid loads the word and drops the guess.
